// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scanner with a double-buffered data register,
// dead-time blanking, PWM dimming, leading-zero suppression and frame-rate blink.
module disp_scan_ctrl #(
   parameter int unsigned CLK_DIV   = 50000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic [3:0]  brightness,
   input  logic        lz_en,
   input  logic        blink_en,
   output logic [1:0]  digit_sel,
   output logic [3:0]  digit_val,
   output logic        digit_on,
   output logic        upd_pend,
   output logic        frame_tick
);

   localparam logic [15:0] CNT_MAX   = 16'(CLK_DIV - 1);
   localparam logic [15:0] BLANK_END = 16'(BLANK_CYC);

   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  sel_q, sel_d;
   logic [3:0]  pwm_q, pwm_d;
   logic [5:0]  frm_q, frm_d;
   logic [15:0] shadow_q, shadow_d;
   logic [15:0] active_q, active_d;
   logic        pend_q, pend_d;
   logic [3:0]  bright_q;
   logic        lz_q;
   logic        blink_q;

   logic        cnt_wrap;
   logic        tick;
   logic        suppressed;
   logic        blanked;

   always_comb begin
      cnt_wrap = (cnt_q == CNT_MAX);
      tick     = cnt_wrap && (sel_q == 2'd3);
      cnt_d    = cnt_wrap ? 16'd0 : cnt_q + 16'd1;
      sel_d    = cnt_wrap ? sel_q + 2'd1 : sel_q;
      pwm_d    = pwm_q + 4'd1;
      frm_d    = tick ? frm_q + 6'd1 : frm_q;
      shadow_d = shadow_q;
      active_d = active_q;
      pend_d   = pend_q;
      if (tick) begin
         active_d = shadow_q;
         pend_d   = 1'b0;
      end
      // A write landing on the boundary goes straight to the active buffer.
      if (wr_en) begin
         shadow_d = wr_data;
         if (tick) begin
            active_d = wr_data;
         end else begin
            pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 16'd0;
         sel_q    <= 2'd0;
         pwm_q    <= 4'd0;
         frm_q    <= 6'd0;
         shadow_q <= 16'd0;
         active_q <= 16'd0;
         pend_q   <= 1'b0;
         bright_q <= 4'd0;
         lz_q     <= 1'b0;
         blink_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         pwm_q    <= pwm_d;
         frm_q    <= frm_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         bright_q <= brightness;
         lz_q     <= lz_en;
         blink_q  <= blink_en;
      end
   end

   // Outputs decode registered state only; control inputs pass through bright_q/lz_q/blink_q.
   always_comb begin
      suppressed = 1'b0;
      if (lz_q) begin
         case (sel_q)
            2'd3:    suppressed = (active_q[15:12] == 4'd0);
            2'd2:    suppressed = (active_q[15:8] == 8'd0);
            2'd1:    suppressed = (active_q[15:4] == 12'd0);
            default: suppressed = 1'b0;
         endcase
      end
      blanked    = blink_q && frm_q[5];
      frame_tick = tick;
      digit_sel  = sel_q;
      digit_val  = active_q[{sel_q, 2'b00} +: 4];
      upd_pend   = pend_q;
      digit_on   = (cnt_q >= BLANK_END) && (pwm_q <= bright_q) && !suppressed && !blanked;
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with CLK_DIV=8, BLANK_CYC=2.
// cyc counts clock edges since reset release; outputs are sampled at the falling edge.
module tb_disp_scan_ctrl;

   localparam int CLK_DIV   = 8;
   localparam int BLANK_CYC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = 16'h0000;
   logic [3:0]  brightness = 4'd15;
   logic        lz_en = 1'b0;
   logic        blink_en = 1'b0;
   logic [1:0]  digit_sel;
   logic [3:0]  digit_val;
   logic        digit_on;
   logic        upd_pend;
   logic        frame_tick;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic blk  = 1'b0;

   always #5 clk = ~clk;

   disp_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .brightness (brightness),
      .lz_en      (lz_en),
      .blink_en   (blink_en),
      .digit_sel  (digit_sel),
      .digit_val  (digit_val),
      .digit_on   (digit_on),
      .upd_pend   (upd_pend),
      .frame_tick (frame_tick)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) next_cyc();
   endtask

   task automatic wr(input logic [15:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      next_cyc();
      wr_en   = 1'b0;
   endtask

   function automatic logic [1:0] exp_sel(input int c);
      return 2'((c / 8) % 4);
   endfunction

   function automatic logic win(input int c);
      return (c % 8) >= 2;
   endfunction

   function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] s);
      return v[int'(s) * 4 +: 4];
   endfunction

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_sel", 32'(digit_sel), 32'd0);
      check("rst_val", 32'(digit_val), 32'd0);
      check("rst_on", 32'(digit_on), 32'd0);
      check("rst_pend", 32'(upd_pend), 32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);
      rst_n = 1'b1;
      cyc   = 0;
      #1;

      // scan order plus tear-free update of 1234 written at cycle 5
      while (cyc <= 64) begin
         check("scan_sel", 32'(digit_sel), 32'(exp_sel(cyc)));
         check("scan_tick", 32'(frame_tick), 32'((cyc % 32) == 31));
         check("scan_on", 32'(digit_on), 32'(win(cyc)));
         check("upd_pend", 32'(upd_pend), 32'(cyc >= 6 && cyc <= 31));
         check("upd_val", 32'(digit_val), 32'((cyc < 32) ? 4'd0 : nib(16'h1234, exp_sel(cyc))));
         wr_en   = (cyc == 5);
         wr_data = 16'h1234;
         next_cyc();
      end
      wr_en = 1'b0;

      // write coincident with the frame boundary
      wait_to(95);
      check("coll_tick", 32'(frame_tick), 32'd1);
      check("coll_pend0", 32'(upd_pend), 32'd0);
      wr(16'hABCD);
      while (cyc < 128) begin
         check("coll_pend", 32'(upd_pend), 32'd0);
         check("coll_val", 32'(digit_val), 32'(nib(16'hABCD, exp_sel(cyc))));
         next_cyc();
      end

      // last write wins, then leading-zero suppression
      lz_en = 1'b1;
      wait_to(130);
      wr(16'h1111);
      wait_to(140);
      wr(16'h0070);
      check("lw_pend", 32'(upd_pend), 32'd1);
      wait_to(160);
      while (cyc < 192) begin
         check("lz_val", 32'(digit_val), 32'(nib(16'h0070, exp_sel(cyc))));
         check("lz70_on", 32'(digit_on), 32'(win(cyc) && exp_sel(cyc) < 2'd2));
         wr_en   = (cyc == 170);
         wr_data = 16'h0000;
         next_cyc();
      end
      wr_en = 1'b0;
      while (cyc < 224) begin
         check("lz00_on", 32'(digit_on), 32'(win(cyc) && exp_sel(cyc) == 2'd0));
         if (cyc == 223) begin
            lz_en      = 1'b0;
            brightness = 4'd3;
         end
         next_cyc();
      end

      // brightness 3: lit only while pwm is 0..3
      while (cyc < 256) begin
         check("pwm_on", 32'(digit_on), 32'(win(cyc) && (cyc % 16) <= 3));
         if (cyc == 255) begin
            brightness = 4'd15;
            blink_en   = 1'b1;
         end
         next_cyc();
      end
      blk = 1'b1;

      // blink over frames 8..69, briefly disabled inside the blanked half
      while (cyc < 2240) begin
         check("blink_on", 32'(digit_on), 32'(win(cyc) && !(blk && ((cyc / 32) % 64) >= 32)));
         if (cyc == 1290) blink_en = 1'b0;
         if (cyc == 1354) blink_en = 1'b1;
         next_cyc();
         blk = blink_en;
      end
      blink_en = 1'b0;

      // asynchronous reset while a write is pending in the digit-2 slot
      wait_to(2245);
      wr(16'h9876);
      wait_to(2272);
      check("pre_val", 32'(digit_val), 32'h6);
      wait_to(2290);
      check("pre_sel", 32'(digit_sel), 32'd2);
      wr(16'h5A5A);
      check("pre_pend", 32'(upd_pend), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_pend", 32'(upd_pend), 32'd0);
      check("arst_sel", 32'(digit_sel), 32'd0);
      check("arst_val", 32'(digit_val), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      #1;
      while (cyc < 64) begin
         check("post_val", 32'(digit_val), 32'd0);
         check("post_sel", 32'(digit_sel), 32'(exp_sel(cyc)));
         check("post_pend", 32'(upd_pend), 32'd0);
         next_cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
